// File: rtl/rx_frame_receiver.sv
// rx_frame_receiver
//   Oversampling asynchronous serial receiver. Detects a start edge on the
//   synchronised line, takes a 3-sample majority vote at mid-bit, shifts
//   DATA_BITS data bits LSB first, checks optional parity and the first
//   stop bit, and holds the received word until the consumer acknowledges.
//
// Ports
//   Clk           : clock, all state changes on the rising edge
//   Rst_n         : asynchronous active-low reset
//   Sample_en     : one-cycle strobe at OVERSAMPLE x baud rate
//   RxD           : asynchronous serial input, idle high
//   RxD_ack       : consumer accepts held word (ignored while RxD_valid=0)
//   RxD_data      : received word
//   RxD_valid     : held word present
//   RxD_idle      : receiver FSM is idle
//   Parity_error  : parity mismatch on held word
//   Frame_error   : first stop bit sampled low on held word
//   Overrun_error : a completed frame was dropped while a word was held
//   Break_detect  : held frame was entirely low (data, parity, stop)
module rx_frame_receiver #(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_MODE = 1,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned OVERSAMPLE  = 16
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Sample_en,
   input  logic                 RxD,
   input  logic                 RxD_ack,
   output logic [DATA_BITS-1:0] RxD_data,
   output logic                 RxD_valid,
   output logic                 RxD_idle,
   output logic                 Parity_error,
   output logic                 Frame_error,
   output logic                 Overrun_error,
   output logic                 Break_detect
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_A    = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] CNT_B    = CW'(OVERSAMPLE/2);
   localparam logic [CW-1:0] CNT_C    = CW'(OVERSAMPLE/2 + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t               state, state_nx;
   logic                 rxd_meta, rxd_sync;
   logic                 armed;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bitcnt;
   logic                 smp_a, smp_b;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 stop0;
   logic                 any_high;
   logic                 done;

   logic maj, cnt_end, mid, last_stop, frame_bad_now;
   logic parity_bad;

   assign maj           = (smp_a & smp_b) | (smp_a & rxd_sync) | (smp_b & rxd_sync);
   assign cnt_end       = (cnt == CNT_LAST);
   assign mid           = Sample_en && (cnt == CNT_C);
   assign last_stop     = (bitcnt == STOP_LAST);
   // First stop bit's vote is still on the wire when STOP_BITS=1.
   assign frame_bad_now = (bitcnt == '0) ? ~maj : ~stop0;

   always_comb begin
      parity_bad = 1'b0;
      if (PARITY_MODE == 1)
         parity_bad = (^shreg) ^ par_bit;
      else if (PARITY_MODE == 2)
         parity_bad = ~((^shreg) ^ par_bit);
   end

   assign RxD_idle = (state == IDLE);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:
            // armed requires a high level seen since reset, so a line that is
            // low at reset release cannot start a frame.
            if (Sample_en && armed && !rxd_sync)
               state_nx = START;
         START:
            if (mid && maj)
               state_nx = IDLE;
            else if (Sample_en && cnt_end)
               state_nx = DATA;
         DATA:
            if (Sample_en && cnt_end && (bitcnt == BIT_LAST))
               state_nx = (PARITY_MODE != 0) ? PARITY : STOP;
         PARITY:
            if (Sample_en && cnt_end)
               state_nx = STOP;
         STOP:
            if (mid && last_stop)
               state_nx = (frame_bad_now && !rxd_sync) ? WAIT_HIGH : IDLE;
         WAIT_HIGH:
            if (Sample_en && rxd_sync)
               state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rxd_meta <= 1'b0;
         rxd_sync <= 1'b0;
         armed    <= 1'b0;
         cnt      <= '0;
         bitcnt   <= '0;
         smp_a    <= 1'b0;
         smp_b    <= 1'b0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         stop0    <= 1'b0;
         any_high <= 1'b0;
         done     <= 1'b0;
      end else begin
         rxd_meta <= RxD;
         rxd_sync <= rxd_meta;
         done     <= 1'b0;
         if (Sample_en) begin
            if (state == IDLE && rxd_sync)
               armed <= 1'b1;
            if (state == IDLE || state == WAIT_HIGH || cnt_end)
               cnt <= '0;
            else
               cnt <= cnt + 1'b1;
            if (cnt == CNT_A)
               smp_a <= rxd_sync;
            if (cnt == CNT_B)
               smp_b <= rxd_sync;
            case (state)
               IDLE: begin
                  bitcnt   <= '0;
                  any_high <= 1'b0;
               end
               DATA: begin
                  if (cnt == CNT_C) begin
                     shreg    <= {maj, shreg[DATA_BITS-1:1]};
                     any_high <= any_high | maj;
                  end
                  if (cnt_end)
                     bitcnt <= (bitcnt == BIT_LAST) ? '0 : bitcnt + 1'b1;
               end
               PARITY: begin
                  if (cnt == CNT_C) begin
                     par_bit  <= maj;
                     any_high <= any_high | maj;
                  end
                  if (cnt_end)
                     bitcnt <= '0;
               end
               STOP: begin
                  if (cnt == CNT_C) begin
                     if (bitcnt == '0)
                        stop0 <= maj;
                     any_high <= any_high | maj;
                     if (last_stop)
                        done <= 1'b1;
                  end
                  if (cnt_end)
                     bitcnt <= bitcnt + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         RxD_data      <= '0;
         RxD_valid     <= 1'b0;
         Parity_error  <= 1'b0;
         Frame_error   <= 1'b0;
         Overrun_error <= 1'b0;
         Break_detect  <= 1'b0;
      end else if (done) begin
         if (!RxD_valid || RxD_ack) begin
            RxD_data      <= shreg;
            RxD_valid     <= 1'b1;
            Parity_error  <= parity_bad;
            Frame_error   <= ~stop0;
            Break_detect  <= ~any_high;
            Overrun_error <= 1'b0;
         end else begin
            Overrun_error <= 1'b1;
         end
      end else if (RxD_valid && RxD_ack) begin
         RxD_valid     <= 1'b0;
         Parity_error  <= 1'b0;
         Frame_error   <= 1'b0;
         Overrun_error <= 1'b0;
         Break_detect  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_frame_receiver.sv
// tb_rx_frame_receiver
//   Directed bench for rx_frame_receiver at default parameters
//   (8 data bits, even parity, 1 stop bit, OVERSAMPLE=16, Sample_en every 4 Clk).
module tb_rx_frame_receiver;

   logic       Clk       = 1'b0;
   logic       Rst_n     = 1'b0;
   logic       Sample_en = 1'b0;
   logic       RxD       = 1'b1;
   logic       RxD_ack   = 1'b0;
   logic [7:0] RxD_data;
   logic       RxD_valid;
   logic       RxD_idle;
   logic       Parity_error;
   logic       Frame_error;
   logic       Overrun_error;
   logic       Break_detect;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned se_ph  = 0;

   localparam int unsigned BIT_CLKS = 64;

   rx_frame_receiver #(
      .DATA_BITS  (8),
      .PARITY_MODE(1),
      .STOP_BITS  (1),
      .OVERSAMPLE (16)
   ) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .Sample_en    (Sample_en),
      .RxD          (RxD),
      .RxD_ack      (RxD_ack),
      .RxD_data     (RxD_data),
      .RxD_valid    (RxD_valid),
      .RxD_idle     (RxD_idle),
      .Parity_error (Parity_error),
      .Frame_error  (Frame_error),
      .Overrun_error(Overrun_error),
      .Break_detect (Break_detect)
   );

   always #5 Clk = ~Clk;

   initial begin
      forever begin
         @(negedge Clk);
         Sample_en = (se_ph == 3);
         se_ph = (se_ph + 1) % 4;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [7:0] d, input logic v,
                             input logic pe, input logic fe, input logic ov, input logic bk);
      check_eq({tag, ".data"},    32'(RxD_data),      32'(d));
      check_eq({tag, ".valid"},   32'(RxD_valid),     32'(v));
      check_eq({tag, ".parity"},  32'(Parity_error),  32'(pe));
      check_eq({tag, ".frame"},   32'(Frame_error),   32'(fe));
      check_eq({tag, ".overrun"}, 32'(Overrun_error), 32'(ov));
      check_eq({tag, ".break"},   32'(Break_detect),  32'(bk));
   endtask

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic send_bit(input logic v);
      RxD = v;
      wait_clk(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++)
         send_bit(d[i]);
      send_bit(p);
      send_bit(1'b1);
   endtask

   task automatic ack_pulse();
      RxD_ack = 1'b1;
      @(negedge Clk);
      RxD_ack = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      // reset state
      wait_clk(3);
      check_word("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reset.idle", 32'(RxD_idle), 32'd1);
      Rst_n = 1'b1;
      wait_clk(40);

      // ack with nothing held is ignored
      ack_pulse();
      check_word("ack_empty", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // clean frame, correct even parity
      send_frame(8'hA5, 1'b0);
      check_word("even_ok", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("even_ok.idle", 32'(RxD_idle), 32'd1);
      ack_pulse();
      check_eq("even_ok.ack_valid", 32'(RxD_valid), 32'd0);

      // wrong parity bit
      send_frame(8'hA5, 1'b1);
      check_word("par_err", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      ack_pulse();
      check_eq("par_err.ack_valid", 32'(RxD_valid), 32'd0);
      check_eq("par_err.ack_flag",  32'(Parity_error), 32'd0);

      // glitch: low for 3 Sample_en periods
      RxD = 1'b0;
      wait_clk(12);
      RxD = 1'b1;
      wait_clk(8);
      check_eq("false_start.in_start", 32'(RxD_idle), 32'd0);
      wait_clk(36);
      check_eq("false_start.idle",  32'(RxD_idle),  32'd1);
      check_eq("false_start.valid", 32'(RxD_valid), 32'd0);
      wait_clk(BIT_CLKS);
      check_eq("false_start.valid_late", 32'(RxD_valid), 32'd0);

      // overrun: two frames, no ack
      send_frame(8'h11, 1'b0);
      send_frame(8'h22, 1'b0);
      check_word("overrun", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      ack_pulse();
      check_eq("overrun.ack_valid", 32'(RxD_valid),     32'd0);
      check_eq("overrun.ack_flag",  32'(Overrun_error), 32'd0);

      // ack landing on the completion cycle of the second frame
      send_frame(8'h11, 1'b0);
      fork
         send_frame(8'h22, 1'b0);
         begin
            int unsigned n;
            logic        seen;
            n = 0;
            seen = 1'b0;
            while (n < 200 && !seen) begin
               @(negedge Clk);
               n++;
               if (!RxD_idle) seen = 1'b1;
            end
            if (seen) begin
               seen = 1'b0;
               n = 0;
               while (n < 900 && !seen) begin
                  @(negedge Clk);
                  n++;
                  if (RxD_idle) seen = 1'b1;
               end
            end
            if (!seen)
               check_eq("ack_sync.timeout", 32'd1, 32'd0);
            RxD_ack = 1'b1;
            @(negedge Clk);
            RxD_ack = 1'b0;
         end
      join
      check_word("ack_on_done", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      ack_pulse();

      // break: line low for 20 bit times
      RxD = 1'b0;
      wait_clk(20 * BIT_CLKS);
      check_word("break", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("break.wait_high", 32'(RxD_idle), 32'd0);
      ack_pulse();
      check_word("break.ack", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_clk(BIT_CLKS);
      check_eq("break.still_low_valid", 32'(RxD_valid), 32'd0);
      check_eq("break.still_low_idle",  32'(RxD_idle),  32'd0);
      RxD = 1'b1;
      wait_clk(2 * BIT_CLKS);
      check_eq("break.released_idle", 32'(RxD_idle), 32'd1);
      send_frame(8'h5A, 1'b0);
      check_word("after_break", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      ack_pulse();

      // reset during data bit 4 of 0x0F; remainder of that frame stays on the wire
      send_bit(1'b0);
      for (int i = 0; i < 4; i++)
         send_bit(1'b1);
      RxD = 1'b0;
      wait_clk(20);
      Rst_n = 1'b0;
      wait_clk(2);
      check_word("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("mid_reset.idle", 32'(RxD_idle), 32'd1);
      Rst_n = 1'b1;
      wait_clk(BIT_CLKS - 22);
      for (int i = 0; i < 4; i++)
         send_bit(1'b0);
      send_bit(1'b1);
      wait_clk(BIT_CLKS);
      check_eq("mid_reset.no_word", 32'(RxD_valid), 32'd0);
      check_eq("mid_reset.idle2",   32'(RxD_idle),  32'd1);
      send_frame(8'h3C, 1'b0);
      check_word("after_reset", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
